// File: rtl/bcp_clause_loader_pkg.sv
// Shared constants, literal/clause types and loader FSM states for the BCP front end.
package sat_pkg;

    localparam int VAR_W      = 8;
    localparam int LIT_W      = VAR_W + 1;
    localparam int MAX_LITS   = 4;
    localparam int CLAUSE_NUM = 8;
    localparam int CNT_W      = $clog2(CLAUSE_NUM + 1);
    localparam int ADDR_W     = $clog2(CLAUSE_NUM);
    localparam int SLOT_W     = $clog2(MAX_LITS + 1);
    localparam int LIDX_W     = $clog2(MAX_LITS);
    localparam int CLAUSE_W   = MAX_LITS * LIT_W;

    typedef struct packed {
        logic             neg;
        logic [VAR_W-1:0] var_idx;
    } lit_t;

    // Packed so that slot 0 lands in the least significant bits of a clause word.
    typedef lit_t [MAX_LITS-1:0] clause_t;

    typedef enum logic [1:0] {
        S_COLLECT,
        S_REQ,
        S_STREAM
    } state_t;

endpackage

// File: rtl/bcp_clause_loader_if.sv
// Host literal stream plus controller sweep signals shared by the loader and its neighbours.
interface bcp_clause_loader_if;
    import sat_pkg::*;

    logic                lit_valid;
    logic                lit_ready;
    logic [LIT_W-1:0]    lit_data;
    logic                lit_last;
    logic                formula_last;
    logic                initial_request;
    logic                mem_en;
    logic [ADDR_W-1:0]   address;
    logic                initial_finish;
    logic [CLAUSE_W-1:0] clause_data;

    modport master (
        output lit_valid, lit_data, lit_last, formula_last,
        output mem_en, address, initial_finish,
        input  lit_ready, initial_request, clause_data
    );

    modport slave (
        input  lit_valid, lit_data, lit_last, formula_last,
        input  mem_en, address, initial_finish,
        output lit_ready, initial_request, clause_data
    );

endinterface

// File: rtl/bcp_clause_loader_fifo.sv
// Synchronous clause-word FIFO with a clear that overrides push and pop in the same cycle.
module clause_fifo
    import sat_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  clause_t          wr_data,
    output clause_t          rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    clause_t           mem [CLAUSE_NUM];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(CLAUSE_NUM));
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == ADDR_W'(CLAUSE_NUM - 1)) ? '0 : wr_ptr + ADDR_W'(1);
            if (do_pop)
                rd_ptr <= (rd_ptr == ADDR_W'(CLAUSE_NUM - 1)) ? '0 : rd_ptr + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while the count says it is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    // The loader gates its pops on a non-empty FIFO, so a pop while empty is a design bug.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && empty && !clear));
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(CLAUSE_NUM));

endmodule

// File: rtl/bcp_clause_loader.sv
// Packs host literals into clause words, requests the initial BCP sweep and serves one
// word per controller address.
module bcp_clause_loader
    import sat_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    bcp_clause_loader_if.slave   bus,
    output logic [CNT_W-1:0]     clause_count,
    output logic                 busy,
    output logic                 err_overlen,
    output logic                 err_seq
);

    state_t            state;
    state_t            next_state;
    logic              active;
    logic [SLOT_W-1:0] slot_idx;
    clause_t           asm_word;
    clause_t           push_word;
    clause_t           head_word;
    logic              phase;
    logic [ADDR_W-1:0] rd_idx;
    logic              fifo_empty;
    logic              fifo_full;
    lit_t              lit_in;
    logic              transfer;
    logic              slot_ok;
    logic              push;
    logic              go_req;
    logic              in_stream;
    logic              finish;
    logic              advance;
    logic              pop;

    assign lit_in    = lit_t'(bus.lit_data);
    assign transfer  = bus.lit_valid && bus.lit_ready;
    assign slot_ok   = (slot_idx < SLOT_W'(MAX_LITS));
    assign push      = transfer && bus.lit_last;
    assign go_req    = push && (bus.formula_last || clause_count == CNT_W'(CLAUSE_NUM - 1));
    assign in_stream = (state == S_STREAM);
    assign finish    = in_stream && bus.initial_finish;
    assign advance   = in_stream && bus.mem_en && phase && !bus.initial_finish;
    assign pop       = advance && !fifo_empty;

    assign bus.clause_data = (in_stream && !fifo_empty) ? head_word : '0;

    clause_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .clear   (finish),
        .wr_data (push_word),
        .rd_data (head_word),
        .count   (clause_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // The closing literal joins the word on the way into the FIFO, not via the register.
    always_comb begin
        push_word = asm_word;
        if (slot_ok)
            push_word[slot_idx[LIDX_W-1:0]] = lit_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_COLLECT;
            active <= 1'b0;
        end else begin
            state  <= next_state;
            active <= 1'b1;
        end
    end

    always_comb begin
        next_state          = state;
        bus.lit_ready       = 1'b0;
        bus.initial_request = 1'b0;
        busy                = 1'b0;
        case (state)
            S_COLLECT: begin
                bus.lit_ready = active && !fifo_full;
                if (go_req)
                    next_state = S_REQ;
            end
            S_REQ: begin
                bus.initial_request = 1'b1;
                busy                = 1'b1;
                next_state          = S_STREAM;
            end
            S_STREAM: begin
                busy = 1'b1;
                if (bus.initial_finish)
                    next_state = S_COLLECT;
            end
            default: next_state = S_COLLECT;
        endcase
    end

    // Slot counter saturates at MAX_LITS so surplus literals are dropped until lit_last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_word    <= '0;
            slot_idx    <= '0;
            err_overlen <= 1'b0;
        end else if (transfer) begin
            if (!slot_ok)
                err_overlen <= 1'b1;
            if (bus.lit_last) begin
                asm_word <= '0;
                slot_idx <= '0;
            end else if (slot_ok) begin
                asm_word[slot_idx[LIDX_W-1:0]] <= lit_in;
                slot_idx                       <= slot_idx + SLOT_W'(1);
            end
        end
    end

    // The read index follows every address, even past a short formula, so empty slots
    // never look like a sequence error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= 1'b0;
            rd_idx  <= '0;
            err_seq <= 1'b0;
        end else if (finish) begin
            phase  <= 1'b0;
            rd_idx <= '0;
        end else if (in_stream && bus.mem_en) begin
            phase <= ~phase;
            if (advance)
                rd_idx <= rd_idx + ADDR_W'(1);
            if (bus.address != rd_idx)
                err_seq <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bcp_clause_loader.sv
// Scoreboard bench: stimulus queues expected clause words, a negedge monitor checks each sweep.
module tb_bcp_clause_loader;
    import sat_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcp_clause_loader_if ifc ();
    logic [CNT_W-1:0] clause_count;
    logic             busy;
    logic             err_overlen;
    logic             err_seq;

    bcp_clause_loader dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (ifc),
        .clause_count (clause_count),
        .busy         (busy),
        .err_overlen  (err_overlen),
        .err_seq      (err_seq)
    );

    int      pass_cnt = 0;
    int      total_cnt = 0;
    int      req_pulses = 0;
    int      exp_req = 0;
    int      formula_clauses = 0;
    int      asm_slots = 0;
    bit      mon_phase = 1'b0;
    clause_t exp_q[$];
    clause_t asm_model = '0;
    lit_t    pend_lit;
    bit      pend_last;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        total_cnt++;
        if (actual === expected)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Each mem_en cycle must show the queued word; the second cycle of an address retires it.
    always @(negedge clk) begin
        if (rst) begin
            mon_phase <= 1'b0;
        end else if (ifc.mem_en) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL clause_data: got 0x%0h, expected no word (scoreboard empty)",
                         ifc.clause_data);
            end else begin
                check_output("clause_data", 64'(ifc.clause_data), 64'(exp_q[0]));
                if (mon_phase)
                    void'(exp_q.pop_front());
            end
            mon_phase <= ~mon_phase;
        end
        if (ifc.initial_request)
            req_pulses <= req_pulses + 1;
    end

    task automatic drive_lit(input bit neg, input int idx, input bit last, input bit flast);
        pend_lit.neg     = neg;
        pend_lit.var_idx = VAR_W'(idx);
        pend_last        = last;
        ifc.lit_valid    = 1'b1;
        ifc.lit_data     = pend_lit;
        ifc.lit_last     = last;
        ifc.formula_last = flast;
    endtask

    task automatic finish_lit();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (ifc.lit_ready === 1'b1)
                ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            if (asm_slots < MAX_LITS) begin
                asm_model[asm_slots] = pend_lit;
                asm_slots++;
            end
            if (pend_last) begin
                exp_q.push_back(asm_model);
                asm_model = '0;
                asm_slots = 0;
                formula_clauses++;
            end
        end else begin
            total_cnt++;
            $display("[TB] FAIL lit_handshake: got lit_ready=0 for 300 cycles, expected 1");
        end
        ifc.lit_valid    = 1'b0;
        ifc.lit_last     = 1'b0;
        ifc.formula_last = 1'b0;
    endtask

    task automatic apply_stimulus(input bit neg, input int idx, input bit last, input bit flast);
        drive_lit(neg, idx, last, flast);
        finish_lit();
    endtask

    task automatic wait_request();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (ifc.initial_request === 1'b1)
                ok = 1'b1;
        end
        if (ok) begin
            exp_req++;
            check_output("count_at_request", 64'(clause_count), 64'(formula_clauses));
        end else begin
            total_cnt++;
            $display("[TB] FAIL initial_request: got no pulse in 300 cycles, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input bit skip, input bit check_bp);
        for (int i = formula_clauses; i < CLAUSE_NUM; i++)
            exp_q.push_back('0);
        for (int a = 0; a < CLAUSE_NUM; a++) begin
            ifc.mem_en  = 1'b1;
            ifc.address = (skip && a != 0) ? ADDR_W'(a + 1) : ADDR_W'(a);
            @(negedge clk);
            if (check_bp)
                check_output("lit_ready_stall", 64'(ifc.lit_ready), 64'(0));
            @(posedge clk);
            @(posedge clk);
            #1;
        end
        ifc.mem_en         = 1'b0;
        ifc.initial_finish = 1'b1;
        @(posedge clk);
        #1;
        ifc.initial_finish = 1'b0;
        formula_clauses    = 0;
        check_output("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        check_output("busy_after_finish", 64'(busy), 64'(0));
        check_output("count_after_finish", 64'(clause_count), 64'(0));
        check_output("req_pulses", 64'(req_pulses), 64'(exp_req));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ifc.lit_valid      = 1'b0;
        ifc.lit_data       = '0;
        ifc.lit_last       = 1'b0;
        ifc.formula_last   = 1'b0;
        ifc.mem_en         = 1'b0;
        ifc.address        = '0;
        ifc.initial_finish = 1'b0;

        // Power-on reset values.
        #12;
        check_output("rst_lit_ready", 64'(ifc.lit_ready), 64'(0));
        check_output("rst_clause_data", 64'(ifc.clause_data), 64'(0));
        check_output("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("ready_after_rst", 64'(ifc.lit_ready), 64'(1));
        @(posedge clk);
        #1;

        // Full formula: eight two-literal clauses (+(i+1), -(i+10)), request on the 8th.
        for (int i = 0; i < CLAUSE_NUM; i++) begin
            apply_stimulus(1'b0, i + 1, 1'b0, 1'b0);
            apply_stimulus(1'b1, i + 10, 1'b1, 1'b0);
        end
        wait_request();
        run_sweep(1'b0, 1'b0);
        @(negedge clk);
        check_output("ready_after_full", 64'(ifc.lit_ready), 64'(1));
        @(posedge clk);
        #1;

        // Short formula: three clauses, the tail of the sweep sees empty words.
        apply_stimulus(1'b0, 1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 2, 1'b0, 1'b0);
        apply_stimulus(1'b0, 3, 1'b1, 1'b0);
        apply_stimulus(1'b1, 4, 1'b1, 1'b0);
        apply_stimulus(1'b0, 5, 1'b0, 1'b0);
        apply_stimulus(1'b1, 6, 1'b1, 1'b1);
        wait_request();
        run_sweep(1'b0, 1'b0);
        check_output("err_seq_short", 64'(err_seq), 64'(0));
        check_output("err_overlen_clean", 64'(err_overlen), 64'(0));

        // Over-length: a var-0 slot clause, then six literals where only four survive.
        apply_stimulus(1'b0, 9, 1'b0, 1'b0);
        apply_stimulus(1'b1, 0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++)
            apply_stimulus(1'b0, i, i == 6, i == 6);
        check_output("err_overlen_set", 64'(err_overlen), 64'(1));

        // Backpressure: a literal is held valid through the request and the whole sweep.
        drive_lit(1'b0, 20, 1'b1, 1'b0);
        wait_request();
        run_sweep(1'b0, 1'b1);
        finish_lit();
        check_output("count_after_held", 64'(clause_count), 64'(1));

        // Sequence error: the controller model skips address 1.
        apply_stimulus(1'b1, 21, 1'b1, 1'b1);
        wait_request();
        run_sweep(1'b1, 1'b0);
        check_output("err_seq_set", 64'(err_seq), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check_output("err_seq_sticky", 64'(err_seq), 64'(1));
        check_output("err_overlen_sticky", 64'(err_overlen), 64'(1));

        // Reset in the middle of a sweep clears everything asynchronously.
        apply_stimulus(1'b0, 30, 1'b1, 1'b1);
        wait_request();
        ifc.mem_en  = 1'b1;
        ifc.address = '0;
        @(negedge clk);
        #2;
        rst        = 1'b1;
        ifc.mem_en = 1'b0;
        #1;
        check_output("midrst_lit_ready", 64'(ifc.lit_ready), 64'(0));
        check_output("midrst_request", 64'(ifc.initial_request), 64'(0));
        check_output("midrst_clause_data", 64'(ifc.clause_data), 64'(0));
        check_output("midrst_count", 64'(clause_count), 64'(0));
        check_output("midrst_busy", 64'(busy), 64'(0));
        check_output("midrst_err_overlen", 64'(err_overlen), 64'(0));
        check_output("midrst_err_seq", 64'(err_seq), 64'(0));
        exp_q.delete();
        formula_clauses = 0;
        asm_model       = '0;
        asm_slots       = 0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("ready_after_midrst", 64'(ifc.lit_ready), 64'(1));
        @(posedge clk);
        #1;

        // Normal operation resumes after the abandoned sweep.
        apply_stimulus(1'b0, 40, 1'b0, 1'b0);
        apply_stimulus(1'b1, 41, 1'b1, 1'b0);
        apply_stimulus(1'b0, 42, 1'b1, 1'b1);
        wait_request();
        run_sweep(1'b0, 1'b0);
        check_output("err_seq_post_rst", 64'(err_seq), 64'(0));

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
